// File: rtl/jts16_sdram_arb_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | jts16_sdram_arb_if : bank request ports and SDRAM command port bundle  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface jts16_sdram_arb_if #(
   parameter int AW = 22
);
   logic          refresh_en;
   logic [AW-1:0] ba0_addr;
   logic          ba0_rd;
   logic          ba0_wr;
   logic [15:0]   ba0_din;
   logic [1:0]    ba0_din_m;
   logic [AW-1:0] ba1_addr;
   logic [AW-1:0] ba2_addr;
   logic [AW-1:0] ba3_addr;
   logic          ba1_rd;
   logic          ba2_rd;
   logic          ba3_rd;
   logic          ba0_ack, ba1_ack, ba2_ack, ba3_ack;
   logic          ba0_rdy, ba1_rdy, ba2_rdy, ba3_rdy;
   logic [AW-1:0] sd_addr;
   logic [1:0]    sd_ba;
   logic          sd_rd;
   logic          sd_wr;
   logic [15:0]   sd_din;
   logic [1:0]    sd_din_m;
   logic          sd_refresh;
   logic          sd_ack;
   logic          sd_rdy;
   logic          busy;

   modport master (
      input  refresh_en, ba0_addr, ba0_rd, ba0_wr, ba0_din, ba0_din_m,
             ba1_addr, ba2_addr, ba3_addr, ba1_rd, ba2_rd, ba3_rd,
             sd_ack, sd_rdy,
      output ba0_ack, ba1_ack, ba2_ack, ba3_ack,
             ba0_rdy, ba1_rdy, ba2_rdy, ba3_rdy,
             sd_addr, sd_ba, sd_rd, sd_wr, sd_din, sd_din_m, sd_refresh, busy
   );

   modport slave (
      output refresh_en, ba0_addr, ba0_rd, ba0_wr, ba0_din, ba0_din_m,
             ba1_addr, ba2_addr, ba3_addr, ba1_rd, ba2_rd, ba3_rd,
             sd_ack, sd_rdy,
      input  ba0_ack, ba1_ack, ba2_ack, ba3_ack,
             ba0_rdy, ba1_rdy, ba2_rdy, ba3_rdy,
             sd_addr, sd_ba, sd_rd, sd_wr, sd_din, sd_din_m, sd_refresh, busy
   );
endinterface
`default_nettype wire

// File: rtl/jts16_sdram_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | jts16_sdram_arb : round-robin 4-bank SDRAM arbiter with auto-refresh  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module jts16_sdram_arb #(
   parameter int AW         = 22,
   parameter int REF_PERIOD = 384
)(
   input  wire logic         clk,
   input  wire logic         rst,
   jts16_sdram_arb_if.master bus
);
   localparam int            CW         = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
   localparam logic [CW-1:0] c_REF_LAST = CW'(REF_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_WAIT = 2'd2,
      ST_REF  = 2'd3
   } state_t;

   state_t        r_state;
   logic [1:0]    r_last;
   logic [1:0]    r_grant;
   logic [CW-1:0] r_cnt;
   logic          r_ref_pend;
   logic          r_sd_rd;
   logic          r_sd_wr;
   logic          r_sd_refresh;
   logic [AW-1:0] r_sd_addr;
   logic [15:0]   r_sd_din;
   logic [1:0]    r_sd_din_m;

   logic [3:0]    w_req;
   logic          w_wrap;
   logic          w_ref_req;
   logic          w_found;
   logic [1:0]    w_pick;
   logic [AW-1:0] w_addr;
   logic          w_write;

   assign w_req     = {bus.ba3_rd, bus.ba2_rd, bus.ba1_rd, bus.ba0_rd | bus.ba0_wr};
   assign w_wrap    = bus.refresh_en && (r_cnt == c_REF_LAST);
   // A wrap in this very cycle already outranks any grant.
   assign w_ref_req = r_ref_pend | w_wrap;

   // Scan downwards so the bank closest after r_last is the one kept.
   always_comb begin
      w_found = 1'b0;
      w_pick  = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         if (w_req[r_last + 2'(k)]) begin
            w_found = 1'b1;
            w_pick  = r_last + 2'(k);
         end
      end
   end

   always_comb begin
      w_addr = bus.ba0_addr;
      case (w_pick)
         2'd1:    w_addr = bus.ba1_addr;
         2'd2:    w_addr = bus.ba2_addr;
         2'd3:    w_addr = bus.ba3_addr;
         default: w_addr = bus.ba0_addr;
      endcase
   end

   assign w_write = (w_pick == 2'd0) && bus.ba0_wr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_last       <= 2'd3;
         r_grant      <= 2'd0;
         r_cnt        <= '0;
         r_ref_pend   <= 1'b0;
         r_sd_rd      <= 1'b0;
         r_sd_wr      <= 1'b0;
         r_sd_refresh <= 1'b0;
         r_sd_addr    <= '0;
         r_sd_din     <= '0;
         r_sd_din_m   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_ref_req) begin
                  r_state      <= ST_REF;
                  r_sd_refresh <= 1'b1;
               end else if (w_found) begin
                  r_state    <= ST_CMD;
                  r_grant    <= w_pick;
                  r_last     <= w_pick;
                  r_sd_addr  <= w_addr;
                  r_sd_wr    <= w_write;
                  r_sd_rd    <= ~w_write;
                  r_sd_din   <= (w_pick == 2'd0) ? bus.ba0_din   : 16'd0;
                  r_sd_din_m <= (w_pick == 2'd0) ? bus.ba0_din_m : 2'd0;
               end
            end
            ST_CMD: begin
               if (bus.sd_ack) begin
                  r_sd_rd <= 1'b0;
                  r_sd_wr <= 1'b0;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus.sd_rdy) r_state <= ST_IDLE;
            end
            ST_REF: begin
               if (bus.sd_ack) begin
                  r_sd_refresh <= 1'b0;
                  r_ref_pend   <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         // Counter updates come last so a wrap re-arms a pending refresh.
         if (!bus.refresh_en) begin
            r_cnt      <= '0;
            r_ref_pend <= 1'b0;
         end else if (w_wrap) begin
            r_cnt      <= '0;
            r_ref_pend <= 1'b1;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign bus.sd_addr    = r_sd_addr;
   assign bus.sd_ba      = r_grant;
   assign bus.sd_rd      = r_sd_rd;
   assign bus.sd_wr      = r_sd_wr;
   assign bus.sd_din     = r_sd_din;
   assign bus.sd_din_m   = r_sd_din_m;
   assign bus.sd_refresh = r_sd_refresh;
   assign bus.busy       = (r_state != ST_IDLE);

   assign bus.ba0_ack = bus.sd_ack && (r_state == ST_CMD)  && (r_grant == 2'd0);
   assign bus.ba1_ack = bus.sd_ack && (r_state == ST_CMD)  && (r_grant == 2'd1);
   assign bus.ba2_ack = bus.sd_ack && (r_state == ST_CMD)  && (r_grant == 2'd2);
   assign bus.ba3_ack = bus.sd_ack && (r_state == ST_CMD)  && (r_grant == 2'd3);
   assign bus.ba0_rdy = bus.sd_rdy && (r_state == ST_WAIT) && (r_grant == 2'd0);
   assign bus.ba1_rdy = bus.sd_rdy && (r_state == ST_WAIT) && (r_grant == 2'd1);
   assign bus.ba2_rdy = bus.sd_rdy && (r_state == ST_WAIT) && (r_grant == 2'd2);
   assign bus.ba3_rdy = bus.sd_rdy && (r_state == ST_WAIT) && (r_grant == 2'd3);
endmodule
`default_nettype wire

// File: tb/tb_jts16_sdram_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_jts16_sdram_arb : directed and randomized bench with a cycle model |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_jts16_sdram_arb;
   localparam int AW     = 22;
   localparam int PERIOD = 8;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   jts16_sdram_arb_if #(.AW(AW)) bus ();

   jts16_sdram_arb #(.AW(AW), .REF_PERIOD(PERIOD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   // Reference model: phase 0 idle, 1 command, 2 wait, 3 refresh
   int          m_phase, m_last, m_grant, m_cnt;
   bit          m_pend, m_rd, m_wr, m_ref;
   logic [AW-1:0] m_addr;
   logic [15:0] m_din;
   logic [1:0]  m_dinm;

   function automatic bit wants(int b);
      case (b)
         0:       return bus.ba0_rd | bus.ba0_wr;
         1:       return bus.ba1_rd;
         2:       return bus.ba2_rd;
         default: return bus.ba3_rd;
      endcase
   endfunction

   function automatic logic [AW-1:0] addr_of(int b);
      case (b)
         0:       return bus.ba0_addr;
         1:       return bus.ba1_addr;
         2:       return bus.ba2_addr;
         default: return bus.ba3_addr;
      endcase
   endfunction

   function automatic void model_step();
      bit wrap;
      bit found;
      if (rst) begin
         m_phase = 0; m_last = 3; m_grant = 0; m_cnt = 0; m_pend = 0;
         m_rd = 0; m_wr = 0; m_ref = 0; m_addr = '0; m_din = '0; m_dinm = '0;
         return;
      end
      wrap  = bus.refresh_en && (m_cnt == PERIOD - 1);
      found = 0;
      if (m_phase == 0) begin
         if (m_pend || wrap) begin
            m_phase = 3;
            m_ref   = 1;
         end else begin
            for (int k = 1; k <= 4; k++) begin
               int b;
               b = (m_last + k) % 4;
               if (!found && wants(b)) begin
                  found   = 1;
                  m_phase = 1;
                  m_grant = b;
                  m_last  = b;
                  m_addr  = addr_of(b);
                  m_wr    = (b == 0) && bus.ba0_wr;
                  m_rd    = !m_wr;
                  m_din   = (b == 0) ? bus.ba0_din : 16'd0;
                  m_dinm  = (b == 0) ? bus.ba0_din_m : 2'd0;
               end
            end
         end
      end else if (m_phase == 1) begin
         if (bus.sd_ack) begin m_rd = 0; m_wr = 0; m_phase = 2; end
      end else if (m_phase == 2) begin
         if (bus.sd_rdy) m_phase = 0;
      end else begin
         if (bus.sd_ack) begin m_ref = 0; m_pend = 0; m_phase = 0; end
      end
      if (!bus.refresh_en) begin
         m_cnt = 0; m_pend = 0;
      end else if (wrap) begin
         m_cnt = 0; m_pend = 1;
      end else begin
         m_cnt = m_cnt + 1;
      end
   endfunction

   function automatic logic [63:0] exp_comb();
      logic [3:0] a, r;
      for (int n = 0; n < 4; n++) begin
         a[n] = bus.sd_ack && (m_phase == 1) && (m_grant == n);
         r[n] = bus.sd_rdy && (m_phase == 2) && (m_grant == n);
      end
      return {56'd0, a, r};
   endfunction

   function automatic logic [63:0] got_comb();
      return {56'd0, bus.ba3_ack, bus.ba2_ack, bus.ba1_ack, bus.ba0_ack,
              bus.ba3_rdy, bus.ba2_rdy, bus.ba1_rdy, bus.ba0_rdy};
   endfunction

   function automatic logic [63:0] exp_regs();
      return {18'd0, (m_phase != 0), m_ref, m_rd, m_wr, 2'(m_grant), m_dinm, m_din, m_addr};
   endfunction

   function automatic logic [63:0] got_regs();
      return {18'd0, bus.busy, bus.sd_refresh, bus.sd_rd, bus.sd_wr, bus.sd_ba,
              bus.sd_din_m, bus.sd_din, bus.sd_addr};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      #1;
      chk("ack_rdy", got_comb(), exp_comb());
      @(posedge clk);
      model_step();
      #1;
      chk("regs", got_regs(), exp_regs());
   endtask

   task automatic idle_inputs();
      bus.ba0_rd = 0; bus.ba0_wr = 0; bus.ba1_rd = 0; bus.ba2_rd = 0; bus.ba3_rd = 0;
      bus.ba0_addr = '0; bus.ba1_addr = '0; bus.ba2_addr = '0; bus.ba3_addr = '0;
      bus.ba0_din = '0; bus.ba0_din_m = '0; bus.sd_ack = 0; bus.sd_rdy = 0;
      bus.refresh_en = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
   endtask

   initial begin
      int q_order[$];
      int exp_order[6];
      int refs;
      logic prev_rd;
      exp_order = '{0, 1, 2, 3, 0, 1};

      idle_inputs();
      rst = 1;
      @(posedge clk);
      model_step();
      #1;
      chk("reset_state", got_regs(), 64'd0);
      rst = 0;

      // Single read on bank 2
      bus.ba2_rd = 1; bus.ba2_addr = 22'h12345;
      tick();
      chk("rd_cmd", {bus.sd_rd, bus.sd_wr, bus.sd_ba}, 64'b1010);
      chk("rd_addr", 64'(bus.sd_addr), 64'h12345);
      tick();
      bus.sd_ack = 1;
      #1 chk("ba2_ack", 64'(bus.ba2_ack), 64'd1);
      tick();
      bus.sd_ack = 0; bus.ba2_rd = 0;
      tick();
      bus.sd_rdy = 1;
      #1 chk("ba2_rdy", 64'(bus.ba2_rdy), 64'd1);
      tick();
      bus.sd_rdy = 0;
      chk("busy_after", 64'(bus.busy), 64'd0);

      // Round-robin with all banks requesting, fixed ack/rdy
      do_reset();
      bus.ba0_rd = 1; bus.ba1_rd = 1; bus.ba2_rd = 1; bus.ba3_rd = 1;
      bus.sd_ack = 1; bus.sd_rdy = 1;
      for (int i = 0; i < 18; i++) begin
         prev_rd = bus.sd_rd;
         tick();
         if (!prev_rd && bus.sd_rd) q_order.push_back(int'(bus.sd_ba));
      end
      chk("rr_count", 64'(q_order.size()), 64'd6);
      for (int i = 0; i < 6; i++)
         if (i < q_order.size()) chk("rr_order", 64'(q_order[i]), 64'(exp_order[i]));

      // Bank 0 write beats read
      do_reset();
      bus.ba0_wr = 1; bus.ba0_rd = 1; bus.ba0_din = 16'hBEEF; bus.ba0_din_m = 2'b01;
      tick();
      chk("wr_cmd", {bus.sd_wr, bus.sd_rd}, 64'b10);
      chk("wr_data", {bus.sd_din_m, bus.sd_din}, {46'd0, 2'b01, 16'hBEEF});

      // Refresh every PERIOD cycles
      do_reset();
      bus.refresh_en = 1; bus.sd_ack = 1;
      refs = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         refs += int'(bus.sd_refresh);
      end
      chk("ref_count", 64'(refs), 64'd5);

      // Refresh disabled
      do_reset();
      bus.sd_ack = 1;
      refs = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         refs += int'(bus.sd_refresh);
      end
      chk("ref_off", 64'(refs), 64'd0);

      // Refresh waits for an in-flight access
      do_reset();
      bus.refresh_en = 1; bus.ba1_rd = 1;
      for (int i = 0; i < 10; i++) tick();
      chk("ref_held", 64'(bus.sd_refresh), 64'd0);
      bus.ba1_rd = 0; bus.sd_ack = 1;
      tick();
      bus.sd_ack = 0; bus.sd_rdy = 1;
      #1 chk("ba1_rdy", 64'(bus.ba1_rdy), 64'd1);
      tick();
      bus.sd_rdy = 0;
      tick();
      chk("ref_after", 64'(bus.sd_refresh), 64'd1);

      // Reset in the middle of a bank 3 wait
      do_reset();
      bus.ba3_rd = 1;
      tick();
      bus.ba3_rd = 0; bus.sd_ack = 1;
      tick();
      bus.sd_ack = 0;
      tick();
      rst = 1;
      tick();
      chk("mid_reset", got_regs(), 64'd0);
      rst = 0; bus.sd_rdy = 1; bus.ba0_rd = 1;
      #1 chk("no_ba3_rdy", 64'(bus.ba3_rdy), 64'd0);
      tick();
      chk("post_reset_grant", {bus.sd_rd, bus.sd_ba}, 64'b100);

      // Randomized traffic
      do_reset();
      bus.refresh_en = 1;
      for (int i = 0; i < 1500; i++) begin
         rst            = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 99) == 0) bus.refresh_en = ~bus.refresh_en;
         bus.ba0_rd     = ($urandom_range(0, 3) == 0);
         bus.ba0_wr     = ($urandom_range(0, 3) == 0);
         bus.ba1_rd     = ($urandom_range(0, 2) == 0);
         bus.ba2_rd     = ($urandom_range(0, 2) == 0);
         bus.ba3_rd     = ($urandom_range(0, 2) == 0);
         bus.ba0_addr   = 22'($urandom);
         bus.ba1_addr   = 22'($urandom);
         bus.ba2_addr   = 22'($urandom);
         bus.ba3_addr   = 22'($urandom);
         bus.ba0_din    = 16'($urandom);
         bus.ba0_din_m  = 2'($urandom);
         bus.sd_ack     = ($urandom_range(0, 2) == 0);
         bus.sd_rdy     = ($urandom_range(0, 2) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/jts16_sdram_arb.md
# jts16_sdram_arb

Arbitrates the four bank request ports of the JTS16 SDRAM memory map (bank 0 R/W for VRAM/RAM/main ROM, banks 1–3 read-only for sound, tiles and objects) onto one single-command SDRAM controller port. It also schedules auto-refresh.

- Sits between the game-side bank slot managers and the SDRAM controller.
- Serialises requests with round-robin fairness.
- Routes the per-bank `ack`/`rdy` handshakes back to the correct requester.

## Interface
Parameters:
- `AW`, 22, SDRAM word address width per bank.
- `REF_PERIOD`, 384, clock cycles between refresh requests while refresh is enabled.

Ports:
- `clk`  in  1  system clock; everything is synchronous to it.
- `rst`  in  1  synchronous, active-high reset.
- `refresh_en`  in  1  refresh allowed (tied to LVBL at top level).
- `ba0_addr`  in  AW  bank 0 address.
- `ba0_rd`  in  1  bank 0 read request.
- `ba0_wr`  in  1  bank 0 write request.
- `ba0_din`  in  16  bank 0 write data.
- `ba0_din_m`  in  2  bank 0 write mask, active high = byte masked.
- `ba1_addr`/`ba2_addr`/`ba3_addr`  in  AW  read-only bank addresses.
- `ba1_rd`/`ba2_rd`/`ba3_rd`  in  1  read requests.
- `ba0_ack`..`ba3_ack`  out  1  request accepted by SDRAM.
- `ba0_rdy`..`ba3_rdy`  out  1  data valid on shared `data_read` / write done.
- `sd_addr`  out  AW  command address.
- `sd_ba`  out  2  command bank.
- `sd_rd`  out  1  read command request.
- `sd_wr`  out  1  write command request.
- `sd_din`  out  16  write data.
- `sd_din_m`  out  2  write mask.
- `sd_refresh`  out  1  refresh command request.
- `sd_ack`  in  1  controller accepted the current command.
- `sd_rdy`  in  1  controller finished the current access.
- `busy`  out  1  high whenever the arbiter is not in IDLE.

## Operation
- States:
  - IDLE: evaluate refresh and requests.
  - CMD: hold command until `sd_ack`.
  - WAIT: hold until `sd_rdy`.
  - REF: hold `sd_refresh` until `sd_ack`.
- IDLE priority:
  - A pending refresh is served first → REF.
  - Otherwise, round-robin search starting at `(last+1) mod 4`. A bank is eligible if its `rd` is high; bank 0 is also eligible if `ba0_wr` is high. First eligible bank is granted → CMD.
- On grant, the command is latched: `sd_ba`=bank, `sd_addr`, `sd_din`, `sd_din_m` (bank 0 only; zero otherwise), and `sd_wr`/`sd_rd`.
  - `ba0_wr` and `ba0_rd` both high: write wins.
  - `last` ← granted bank.
- CMD: the command is held stable. When `sd_ack`=1, `sd_rd`/`sd_wr` drop on the next edge → WAIT.
- WAIT: when `sd_rdy`=1 → IDLE.
- `baN_ack` = `sd_ack` & (state==CMD) & grant==N. Combinational, single-cycle.
- `baN_rdy` = `sd_rdy` & (state==WAIT) & grant==N. Combinational, so it aligns with `data_read`.
- A requester dropping its request after grant does not abort the access; `ack`/`rdy` are still delivered.
- Refresh counter:
  - Counts 0..REF_PERIOD-1 while `refresh_en`=1. At REF_PERIOD-1 it wraps and sets `ref_pend`.
  - `refresh_en`=0 clears the counter and `ref_pend` (even while in REF, the current REF completes on `sd_ack`).
  - `ref_pend` clears when `sd_ack` is seen in REF.
  - Refresh never preempts CMD/WAIT.
- `sd_ack`/`sd_rdy` arriving outside CMD/REF/WAIT respectively are ignored.

## Timing
- Reset: state IDLE, `last`=3 (bank 0 searched first), counter 0, `ref_pend`=0. All outputs are 0: `sd_*`, `busy`, every `ack`/`rdy`.
- Request sampled in IDLE at edge t → `sd_rd`/`sd_wr` high from t+1.
- Minimum transaction = 3 cycles: IDLE, CMD with `sd_ack`, WAIT with `sd_rdy`. Next grant issues on the cycle after the `sd_rdy` cycle.
- `sd_ack` and `sd_rdy` in the same CMD cycle: only the ack is honoured; the arbiter waits for a later `sd_rdy`. The controller guarantees rdy ≥1 cycle after ack.
- Reset mid-transaction: abandon immediately; all outputs 0 on the next cycle.
- Counter wrap coinciding with a grant in IDLE: the refresh wins; the grant is deferred.

## Test plan
- Single read: `ba2_rd`=1, addr 0x12345. Expect `sd_rd`=1, `sd_ba`=2, `sd_addr`=0x12345 one cycle later. Ack after 2 cycles → `ba2_ack` pulse. `sd_rdy` → `ba2_rdy` in the same cycle; `busy` low after.
- Round-robin: hold all four `rd` high with ack/rdy at fixed latency. Expect grant order 0,1,2,3,0,1 and no bank served twice before the others.
- Bank 0 write: `ba0_wr`=1, `ba0_rd`=1, din 0xBEEF, mask 2'b01. Expect `sd_wr`=1, `sd_rd`=0, `sd_din`=0xBEEF, `sd_din_m`=01.
- Refresh: `refresh_en`=1, REF_PERIOD=8, no requests. Expect `sd_refresh` every 8 cycles. With `ba1_rd` active, refresh is issued only after `ba1_rdy`. With `refresh_en`=0, `sd_refresh` is never issued.
- Reset mid-WAIT: pulse `rst` while waiting on `ba3`. Expect all outputs 0 next cycle and no `ba3_rdy` from a late `sd_rdy`. The next request from `ba0` is granted first.
